// File: rtl/keypad_time_entry.sv
// keypad_time_entry
//
// Collects BCD digits from the microwave keypad priority encoder into a
// four-digit MM:SS entry register and, on start, offers the entered time
// to the countdown timer through a valid/ack handshake. The seconds field
// is clamped to 59 when the handoff begins.
//
// Optional feature macro: KEYPAD_DEBOUNCE_EN
//   When defined, a saturating-counter filter sits between the registered
//   key-valid flag and the press edge detector. A new filtered level is only
//   accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
//
// Ports
//   clk          in   1   system clock, rising edge
//   resetn       in   1   synchronous active-low reset
//   bcd_in       in   4   encoder digit, values above 9 ignored
//   loadn_in     in   1   encoder key-valid flag (one key held)
//   clear        in   1   cancel key, returns to IDLE from any state
//   start        in   1   hand the entered time to the timer
//   time_ack     in   1   timer has taken time_out
//   time_out     out  16  {min_tens, min_units, sec_tens, sec_units}
//   digit_count  out  3   digits entered so far, 0..4
//   time_valid   out  1   time_out offered to the timer
//   entry_state  out  2   IDLE=0, ENTRY=1, HOLD=2

module keypad_time_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  bcd_in,
    input  logic        loadn_in,
    input  logic        clear,
    input  logic        start,
    input  logic        time_ack,
    output logic [15:0] time_out,
    output logic [2:0]  digit_count,
    output logic        time_valid,
    output logic [1:0]  entry_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  count_q, count_d;

    logic        s_q;
    logic [3:0]  bcd_q;
    logic        prev_q;

    logic        edgeSrc;
    logic [3:0]  edgeBcd;
    logic        accept;

    // Input registers: key flag and digit are captured on the same edge so
    // the digit always belongs to the sample that produced the press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_q   <= 1'b0;
            bcd_q <= 4'd0;
        end else begin
            s_q   <= loadn_in;
            bcd_q <= bcd_in;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CYCLES);

    logic       filt_q;
    logic [3:0] cnt_q;
    logic [3:0] fbcd_q;

    // The filtered level flips only after DEB_LIMIT consecutive samples
    // disagree with it; any agreeing sample restarts the count, so short
    // glitches never reach the edge detector. The digit is latched in the
    // toggle cycle so it travels with the filtered press.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            filt_q <= 1'b0;
            cnt_q  <= 4'd0;
            fbcd_q <= 4'd0;
        end else if (s_q == filt_q) begin
            cnt_q <= 4'd0;
        end else if (cnt_q + 4'd1 == DEB_LIMIT) begin
            filt_q <= ~filt_q;
            cnt_q  <= 4'd0;
            fbcd_q <= bcd_q;
        end else if (cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign edgeSrc = filt_q;
    assign edgeBcd = fbcd_q;
`else
    logic unusedDebounceCfg;
    assign unusedDebounceCfg = ^DEBOUNCE_CYCLES;

    assign edgeSrc = s_q;
    assign edgeBcd = bcd_q;
`endif

    // One accept per press: only the 0->1 transition of the key level
    // counts, and non-decimal codes from the encoder are dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= edgeSrc;
        end
    end

    assign accept = edgeSrc & ~prev_q & (edgeBcd <= 4'd9);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            digits_q <= 16'h0000;
            count_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
        end
    end

    // Clear beats everything; within ENTRY, start beats a same-cycle accept.
    // Because digits are always legal BCD, seconds exceed 59 exactly when
    // the tens digit is 6 or more, which is all the clamp has to test.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        if (clear) begin
            state_d  = IDLE;
            digits_d = 16'h0000;
            count_d  = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        digits_d = {12'h000, edgeBcd};
                        count_d  = 3'd1;
                        state_d  = ENTRY;
                    end
                end
                ENTRY: begin
                    if (start) begin
                        state_d = HOLD;
                        if (digits_q[7:4] > 4'd5) begin
                            digits_d[7:0] = 8'h59;
                        end
                    end else if (accept && (count_q != 3'd4)) begin
                        digits_d = {digits_q[11:0], edgeBcd};
                        count_d  = count_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (time_ack) begin
                        state_d  = IDLE;
                        digits_d = 16'h0000;
                        count_d  = 3'd0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    digits_d = 16'h0000;
                    count_d  = 3'd0;
                end
            endcase
        end
    end

    assign time_out    = digits_q;
    assign digit_count = count_q;
    assign time_valid  = (state_q == HOLD);
    assign entry_state = state_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry
//
// Directed bench for keypad_time_entry. A digit-list model tracks the
// entered time, count and state from the keypad rules, and a negedge
// process compares all outputs against it whenever the model is settled.
// Literal expectations pin the model at key points of each scenario.
// Defining KEYPAD_DEBOUNCE_EN also exercises the debounce filter.

module tb_keypad_time_entry;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif
    // Edges from the press edge (s becomes 1) to the digit appearing.
    localparam int LAT = 1 + DEB;

    typedef enum int {
        OP_RESET,
        OP_PRESS,
        OP_PRESS_START,
        OP_START,
        OP_ACK,
        OP_CLEAR,
        OP_GLITCH
    } op_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  bcd_in;
    logic        loadn_in;
    logic        clear;
    logic        start;
    logic        time_ack;
    logic [15:0] time_out;
    logic [2:0]  digit_count;
    logic        time_valid;
    logic [1:0]  entry_state;

    int checks = 0;
    int passes = 0;
    bit checkEn = 1'b0;

    int md[4];
    int mCount;
    int mState;

    keypad_time_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bcd_in      (bcd_in),
        .loadn_in    (loadn_in),
        .clear       (clear),
        .start       (start),
        .time_ack    (time_ack),
        .time_out    (time_out),
        .digit_count (digit_count),
        .time_valid  (time_valid),
        .entry_state (entry_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] expTime();
        return 16'((md[0] << 12) | (md[1] << 8) | (md[2] << 4) | md[3]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelFlush();
        md = '{0, 0, 0, 0};
        mCount = 0;
        mState = 0;
    endfunction

    function automatic void modelAccept(input int d);
        if (d > 9) return;
        if (mState == 0) begin
            md = '{0, 0, 0, d};
            mCount = 1;
            mState = 1;
        end else if (mState == 1 && mCount < 4) begin
            md[0] = md[1];
            md[1] = md[2];
            md[2] = md[3];
            md[3] = d;
            mCount++;
        end
    endfunction

    function automatic void modelStart();
        if (mState == 1) begin
            if (md[2] * 10 + md[3] > 59) begin
                md[2] = 5;
                md[3] = 9;
            end
            mState = 2;
        end
    endfunction

    function automatic void modelAck();
        if (mState == 2) modelFlush();
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("time_out", 32'(time_out), 32'(expTime()));
            checkOutput("digit_count", 32'(digit_count), 32'(mCount));
            checkOutput("time_valid", 32'(time_valid), 32'(mState == 2));
            checkOutput("entry_state", 32'(entry_state), 32'(mState));
        end
    end

    // Every operation starts and ends 1 time unit after a rising edge.
    task automatic applyStimulus(input op_t op, input int d, input int hold);
        case (op)
            OP_RESET: begin
                checkEn  = 1'b0;
                resetn   = 1'b0;
                bcd_in   = 4'd0;
                loadn_in = 1'b0;
                clear    = 1'b0;
                start    = 1'b0;
                time_ack = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                resetn = 1'b1;
                modelFlush();
                checkOutput("reset_time_out", 32'(time_out), 32'h0);
                checkOutput("reset_count", 32'(digit_count), 32'd0);
                checkOutput("reset_valid", 32'(time_valid), 32'd0);
                checkOutput("reset_state", 32'(entry_state), 32'd0);
                checkEn = 1'b1;
            end
            OP_PRESS: begin
                checkEn  = 1'b0;
                bcd_in   = 4'(d);
                loadn_in = 1'b1;
                repeat (LAT) @(posedge clk);
                #1;
                checkOutput("pre_latency_count", 32'(digit_count), 32'(mCount));
                @(posedge clk);
                #1;
                modelAccept(d);
                checkEn = 1'b1;
                if (hold > LAT + 1) begin
                    repeat (hold - LAT - 1) @(posedge clk);
                    #1;
                end
                loadn_in = 1'b0;
                repeat (LAT + 2) @(posedge clk);
                #1;
            end
            OP_PRESS_START: begin
                checkEn  = 1'b0;
                bcd_in   = 4'(d);
                loadn_in = 1'b1;
                repeat (LAT) @(posedge clk);
                #1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start    = 1'b0;
                loadn_in = 1'b0;
                modelStart();
                checkEn = 1'b1;
                repeat (LAT + 2) @(posedge clk);
                #1;
            end
            OP_START: begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                modelStart();
            end
            OP_ACK: begin
                time_ack = 1'b1;
                @(posedge clk);
                #1;
                time_ack = 1'b0;
                modelAck();
            end
            OP_CLEAR: begin
                clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
                modelFlush();
            end
            OP_GLITCH: begin
                bcd_in   = 4'(d);
                loadn_in = 1'b1;
                repeat (hold) @(posedge clk);
                #1;
                loadn_in = 1'b0;
                repeat (LAT + 2) @(posedge clk);
                #1;
            end
            default: ;
        endcase
    endtask

    initial begin
        resetn   = 1'b0;
        bcd_in   = 4'd0;
        loadn_in = 1'b0;
        clear    = 1'b0;
        start    = 1'b0;
        time_ack = 1'b0;
        modelFlush();
        @(posedge clk);
        #1;

        $display("[TB] reset and basic entry");
        applyStimulus(OP_RESET, 0, 0);
        applyStimulus(OP_PRESS, 1, 3);
        applyStimulus(OP_PRESS, 3, 3);
        applyStimulus(OP_PRESS, 0, 3);
        checkOutput("lit_0130_time", 32'(time_out), 32'h0130);
        checkOutput("lit_0130_count", 32'(digit_count), 32'd3);
        checkOutput("lit_0130_state", 32'(entry_state), 32'd1);

        $display("[TB] saturation at four digits");
        applyStimulus(OP_CLEAR, 0, 0);
        for (int i = 1; i <= 5; i++) applyStimulus(OP_PRESS, i, 3);
        checkOutput("lit_1234_time", 32'(time_out), 32'h1234);
        checkOutput("lit_1234_count", 32'(digit_count), 32'd4);

        $display("[TB] start clamp and handshake");
        applyStimulus(OP_CLEAR, 0, 0);
        applyStimulus(OP_PRESS, 2, 3);
        applyStimulus(OP_PRESS, 7, 3);
        applyStimulus(OP_PRESS, 5, 3);
        applyStimulus(OP_START, 0, 0);
        checkOutput("lit_0259_time", 32'(time_out), 32'h0259);
        checkOutput("lit_0259_valid", 32'(time_valid), 32'd1);
        applyStimulus(OP_PRESS, 8, 3);
        checkOutput("lit_hold_press_time", 32'(time_out), 32'h0259);
        applyStimulus(OP_ACK, 0, 0);
        checkOutput("lit_ack_valid", 32'(time_valid), 32'd0);
        checkOutput("lit_ack_time", 32'(time_out), 32'h0);
        checkOutput("lit_ack_state", 32'(entry_state), 32'd0);

        $display("[TB] clear during hold, start in idle");
        applyStimulus(OP_PRESS, 4, 3);
        applyStimulus(OP_PRESS, 5, 3);
        applyStimulus(OP_START, 0, 0);
        checkOutput("lit_0045_time", 32'(time_out), 32'h0045);
        applyStimulus(OP_CLEAR, 0, 0);
        checkOutput("lit_clear_valid", 32'(time_valid), 32'd0);
        checkOutput("lit_clear_time", 32'(time_out), 32'h0);
        applyStimulus(OP_START, 0, 0);
        checkOutput("lit_idle_start_state", 32'(entry_state), 32'd0);
        applyStimulus(OP_ACK, 0, 0);

        $display("[TB] long hold and press with start");
        applyStimulus(OP_PRESS, 6, 20);
        checkOutput("lit_hold20_count", 32'(digit_count), 32'd1);
        checkOutput("lit_hold20_time", 32'(time_out), 32'h0006);
        applyStimulus(OP_PRESS_START, 7, 0);
        checkOutput("lit_pstart_state", 32'(entry_state), 32'd2);
        checkOutput("lit_pstart_time", 32'(time_out), 32'h0006);
        applyStimulus(OP_ACK, 0, 0);

        $display("[TB] maximum time and non-decimal code");
        for (int i = 0; i < 4; i++) applyStimulus(OP_PRESS, 9, 3);
        applyStimulus(OP_START, 0, 0);
        checkOutput("lit_9959_time", 32'(time_out), 32'h9959);
        applyStimulus(OP_CLEAR, 0, 0);
        applyStimulus(OP_PRESS, 12, 3);
        checkOutput("lit_bad_code_count", 32'(digit_count), 32'd0);
        checkOutput("lit_bad_code_state", 32'(entry_state), 32'd0);

`ifdef KEYPAD_DEBOUNCE_EN
        $display("[TB] debounce filter");
        applyStimulus(OP_GLITCH, 3, 3);
        checkOutput("lit_glitch_count", 32'(digit_count), 32'd0);
        applyStimulus(OP_PRESS, 6, 6);
        checkOutput("lit_deb_count", 32'(digit_count), 32'd1);
        checkOutput("lit_deb_time", 32'(time_out), 32'h0006);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_time_entry.md
# keypad_time_entry

- Sits directly downstream of the microwave keypad priority encoder.
- Takes the encoder's BCD digit and its key-valid flag, detects each new key press, and shifts the digits into a 4-digit MM:SS entry register.
- On `start`, it presents the entered time to the countdown timer through a valid/ack handshake, with the seconds field clamped to a legal value.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples of `loadn_in` required to change the filtered key state. Used only with `KEYPAD_DEBOUNCE_EN`. Legal range 2–15.
- `clk`  input  1  system clock; everything is updated on the rising edge.
- `resetn`  input  1  reset, synchronous, active-low.
- `bcd_in`  input  4  BCD digit from the encoder; values above 9 are ignored.
- `loadn_in`  input  1  key-valid flag from the encoder; 1 means exactly one key is held.
- `clear`  input  1  synchronous clear request (cancel key).
- `start`  input  1  request to hand the entered time to the timer.
- `time_ack`  input  1  timer has taken `time_out`.
- `time_out`  output  16  four BCD digits, `{min_tens, min_units, sec_tens, sec_units}`.
- `digit_count`  output  3  digits entered so far, 0–4.
- `time_valid`  output  1  `time_out` is stable and offered to the timer.
- `entry_state`  output  2  current state: IDLE=0, ENTRY=1, HOLD=2.

## Operation
- **Press detection:**
  - `loadn_in` is registered into `s`, and `prev` is `s` delayed one cycle.
  - A press is accepted only when `s`=1 and `prev`=0 (rising edge), so one accept per press regardless of hold time.
  - The digit captured is the registered `bcd_in` from the same cycle as `s`.
- **States:**
  - IDLE:
    - `digit_count`=0 and `time_out`=0.
    - A valid accept writes the digit into `sec_units`, sets `digit_count`=1 and moves to ENTRY.
    - `start` is ignored.
  - ENTRY:
    - Each valid accept shifts the digits left by one position and writes the new digit into `sec_units`.
    - `digit_count` increments, saturating at 4; with 4 digits held, further accepts are discarded.
    - `start` moves to HOLD.
  - HOLD:
    - `time_valid`=1 and `time_out` is frozen; accepts and `start` are ignored.
    - On `time_ack`=1: `time_valid` drops at the next edge, digits and count are cleared, state goes to IDLE.
- **Start normalisation:** on the ENTRY→HOLD edge, if `{sec_tens, sec_units}` is above 59, both are forced to 5 and 9. Minutes are never modified; 99:59 is the maximum.
- **`clear`:** in any state, zeroes the digits and count, deasserts `time_valid` and goes to IDLE. An in-flight handshake is abandoned.
- **Priority:** `resetn` > `clear` > `start` > key accept.
  - `start` and an accept in the same cycle: the digit is discarded.
  - `time_ack` and an accept in HOLD: the accept is discarded.
- `time_ack` outside HOLD has no effect.

## Timing
- **Reset:** `time_out`=0, `digit_count`=0, `time_valid`=0, `entry_state`=IDLE; `s`, `prev` and the debounce filter are cleared to 0.
- **Key latency (debounce off):**
  - `loadn_in` goes high before edge k; `s`=1 after edge k.
  - The digit appears on `time_out` and `digit_count` after edge k+1.
- **Key latency (debounce on):** `DEBOUNCE_CYCLES` edges later than with debounce off.
- **`start` latency:** `start` high at edge k gives `time_valid`=1 and the clamped `time_out` after edge k.
- **`time_ack` latency:** `time_ack` high at edge k while `time_valid`=1 gives `time_valid`=0, `time_out`=0 and IDLE after edge k.
- **`clear` latency:** `clear` at edge k takes effect after edge k.
- **Release:** release between presses only has to last long enough for `s` to return to 0 (filtered state, if debounce is enabled). Holding a key never repeats it.

## Configuration
- **`KEYPAD_DEBOUNCE_EN` defined:**
  - A filter sits between `s` and edge detection.
  - A saturating 4-bit counter counts consecutive cycles where `s` differs from the filtered value.
  - The filtered value toggles when the count reaches `DEBOUNCE_CYCLES`; the counter resets whenever `s` equals the filtered value.
  - The edge detector and digit capture use the filtered value, with `bcd_in` sampled in the toggle cycle.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- **Not defined:** no counter and no filter; `s` feeds the edge detector directly, and `DEBOUNCE_CYCLES` is unused.

## Test plan
- Reset, then presses 1, 3, 0 with 3-cycle gaps → `time_out`=16'h0130, `digit_count`=3, state ENTRY.
- Presses 1,2,3,4,5 → `time_out`=16'h1234, `digit_count`=4; the fifth press is discarded.
- Enter 2,7,5 then `start`:
  - `time_out`=16'h0259, `time_valid`=1.
  - A press of 8 during HOLD is ignored.
  - `time_ack` → `time_valid`=0, `time_out`=0, IDLE next cycle.
- `clear` asserted while in HOLD with 16'h0045 → `time_valid`=0, `time_out`=0 after one edge. `start` in IDLE → no change.
- Press 6 held for 20 cycles → exactly one digit captured. Press 7 asserted together with `start` in ENTRY → digit discarded and HOLD entered.
- `KEYPAD_DEBOUNCE_EN` with `DEBOUNCE_CYCLES`=4:
  - A 3-cycle pulse on `loadn_in` → no capture.
  - A 6-cycle pulse → one capture, 4 edges later than the non-debounce build.
